// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM with memory wait timeouts and exception sequencing.
// Strobes and write enables are decoded from the current state (BR_EXE pc_wr follows alu_zero_i).
module mc_ctrl #(
    parameter int unsigned ALU_OP_W = 3,
    parameter int unsigned TIMEOUT  = 15,
    parameter bit          EXC_EN   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          opcode_i,
    input  logic [5:0]          funct_i,
    input  logic                shamt_z_i,
    input  logic                alu_zero_i,
    input  logic                alu_ovf_i,
    input  logic                im_ready_i,
    input  logic                dm_ready_i,
    output logic                im_rd_o,
    output logic                dm_rd_o,
    output logic                dm_wr_o,
    output logic                ir_wr_o,
    output logic                pc_wr_o,
    output logic                rf_wr_o,
    output logic                epc_wr_o,
    output logic                alu_src_o,
    output logic                ext_op_o,
    output logic [1:0]          rf_waddr_sel_o,
    output logic [1:0]          rf_wdata_sel_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [1:0]          npc_op_o,
    output logic [4:0]          exc_code_o,
    output logic                exc_flag_o,
    output logic [3:0]          state_o
);

    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [4:0] EXC_IFETCH = 5'd6;
    localparam logic [4:0] EXC_DBUS   = 5'd7;
    localparam logic [4:0] EXC_RI     = 5'd10;
    localparam logic [4:0] EXC_OVF    = 5'd12;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        ALU_EXE = 4'd2,
        ALU_WB  = 4'd3,
        MEM_ADR = 4'd4,
        MEM_RD  = 4'd5,
        MEM_WR  = 4'd6,
        MEM_WB  = 4'd7,
        BR_EXE  = 4'd8,
        JMP_EXE = 4'd9,
        EXC     = 4'd10
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        cause_q, cause_d;
    logic [4:0]        exc_code_q;
    logic              exc_flag_q;

    // Instruction decode from the external IR (stable from DECODE onwards)
    logic is_r, is_addu, is_subu, is_add, is_sub, is_jr, is_ralu;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    assign is_r    = (opcode_i == OP_RTYPE);
    assign is_addu = is_r && shamt_z_i && (funct_i == 6'b100001);
    assign is_subu = is_r && shamt_z_i && (funct_i == 6'b100011);
    assign is_add  = is_r && shamt_z_i && (funct_i == 6'b100000);
    assign is_sub  = is_r && shamt_z_i && (funct_i == 6'b100010);
    assign is_jr   = is_r && (funct_i == 6'b001000);
    assign is_ralu = is_addu || is_subu || is_add || is_sub;
    assign is_ori  = (opcode_i == OP_ORI);
    assign is_lui  = (opcode_i == OP_LUI);
    assign is_lw   = (opcode_i == OP_LW);
    assign is_sw   = (opcode_i == OP_SW);
    assign is_beq  = (opcode_i == OP_BEQ);
    assign is_j    = (opcode_i == OP_J);
    assign is_jal  = (opcode_i == OP_JAL);

    logic waiting_c, timeout_c;
    assign waiting_c = ((state_q == FETCH) && !im_ready_i) ||
                       (((state_q == MEM_RD) || (state_q == MEM_WR)) && !dm_ready_i);
    assign timeout_c = (TIMEOUT != 0) && EXC_EN && (cnt_q == CNT_W'(TO_LIM));

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        im_rd_o        = 1'b0;
        dm_rd_o        = 1'b0;
        dm_wr_o        = 1'b0;
        ir_wr_o        = 1'b0;
        pc_wr_o        = 1'b0;
        rf_wr_o        = 1'b0;
        epc_wr_o       = 1'b0;
        alu_src_o      = 1'b0;
        ext_op_o       = 1'b0;
        rf_waddr_sel_o = 2'd0;
        rf_wdata_sel_o = 2'd0;
        alu_op_o       = ALU_OP_W'(0);
        npc_op_o       = 2'd0;
        unique case (state_q)
            FETCH: begin
                im_rd_o = 1'b1;
                if (im_ready_i) begin
                    ir_wr_o = 1'b1;
                    pc_wr_o = 1'b1;
                    state_d = DECODE;
                end else if (timeout_c) begin
                    cause_d = EXC_IFETCH;
                    state_d = EXC;
                end
            end
            DECODE: begin
                if (is_ralu || is_ori || is_lui)  state_d = ALU_EXE;
                else if (is_lw || is_sw)          state_d = MEM_ADR;
                else if (is_beq)                  state_d = BR_EXE;
                else if (is_j || is_jal || is_jr) state_d = JMP_EXE;
                else if (EXC_EN) begin
                    cause_d = EXC_RI;
                    state_d = EXC;
                end else                          state_d = FETCH;
            end
            ALU_EXE: begin
                if (is_subu || is_sub) alu_op_o = ALU_OP_W'(1);
                else if (is_ori)       alu_op_o = ALU_OP_W'(2);
                else if (is_lui)       alu_op_o = ALU_OP_W'(3);
                alu_src_o = is_ori || is_lui;
                if ((is_add || is_sub) && alu_ovf_i && EXC_EN) begin
                    cause_d = EXC_OVF;
                    state_d = EXC;
                end else begin
                    state_d = ALU_WB;
                end
            end
            ALU_WB: begin
                rf_wr_o        = 1'b1;
                rf_waddr_sel_o = (is_ori || is_lui) ? 2'd1 : 2'd0;
                state_d        = FETCH;
            end
            MEM_ADR: begin
                alu_src_o = 1'b1;
                ext_op_o  = 1'b1;
                state_d   = is_lw ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                dm_rd_o = 1'b1;
                if (dm_ready_i) state_d = MEM_WB;
                else if (timeout_c) begin
                    cause_d = EXC_DBUS;
                    state_d = EXC;
                end
            end
            MEM_WR: begin
                dm_wr_o = 1'b1;
                if (dm_ready_i) state_d = FETCH;
                else if (timeout_c) begin
                    cause_d = EXC_DBUS;
                    state_d = EXC;
                end
            end
            MEM_WB: begin
                rf_wr_o        = 1'b1;
                rf_wdata_sel_o = 2'd1;
                rf_waddr_sel_o = 2'd1;
                state_d        = FETCH;
            end
            BR_EXE: begin
                alu_op_o = ALU_OP_W'(1);
                pc_wr_o  = alu_zero_i;
                npc_op_o = alu_zero_i ? 2'd1 : 2'd0;
                state_d  = FETCH;
            end
            JMP_EXE: begin
                pc_wr_o  = 1'b1;
                npc_op_o = 2'd2;
                if (is_jal) begin
                    rf_wr_o        = 1'b1;
                    rf_waddr_sel_o = 2'd2;
                    rf_wdata_sel_o = 2'd2;
                end
                state_d = FETCH;
            end
            EXC: begin
                epc_wr_o = 1'b1;
                pc_wr_o  = 1'b1;
                npc_op_o = 2'd3;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Reset holds FETCH strobes but must never let a write through
        if (rst) begin
            ir_wr_o = 1'b0;
            pc_wr_o = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            cnt_q      <= '0;
            cause_q    <= 5'd0;
            exc_code_q <= 5'd0;
            exc_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (waiting_c && (TIMEOUT != 0))
                cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == EXC) begin
                exc_code_q <= cause_q;
                exc_flag_q <= 1'b1;
            end
        end
    end

    assign exc_code_o = exc_code_q;
    assign exc_flag_o = exc_flag_q;
    assign state_o    = 4'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: instruction flows, waits, timeouts, exceptions and reset.
module tb_mc_ctrl;

    localparam logic [5:0] OP_ORI = 6'b001101, OP_LW  = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_JAL = 6'b000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic shamt_z = 1'b0, alu_zero = 1'b0, alu_ovf = 1'b0, im_ready = 1'b0, dm_ready = 1'b0;

    logic im_rd, dm_rd, dm_wr, ir_wr, pc_wr, rf_wr, epc_wr, alu_src, ext_op, exc_flag;
    logic [1:0] waddr_sel, wdata_sel, npc_op;
    logic [2:0] alu_op;
    logic [4:0] exc_code;
    logic [3:0] state;

    logic n_im_rd, n_dm_rd, n_dm_wr, n_ir_wr, n_pc_wr, n_rf_wr, n_epc_wr, n_alu_src, n_ext_op, n_exc_flag;
    logic [1:0] n_waddr_sel, n_wdata_sel, n_npc_op;
    logic [2:0] n_alu_op;
    logic [4:0] n_exc_code;
    logic [3:0] n_state;

    logic e_im_rd, e_dm_rd, e_dm_wr, e_ir_wr, e_pc_wr, e_rf_wr, e_epc_wr, e_alu_src, e_ext_op, e_exc_flag;
    logic [1:0] e_waddr_sel, e_wdata_sel, e_npc_op;
    logic [2:0] e_alu_op;
    logic [4:0] e_exc_code;
    logic [3:0] e_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.ALU_OP_W(3), .TIMEOUT(4), .EXC_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode_i(opcode), .funct_i(funct), .shamt_z_i(shamt_z),
        .alu_zero_i(alu_zero), .alu_ovf_i(alu_ovf), .im_ready_i(im_ready), .dm_ready_i(dm_ready),
        .im_rd_o(im_rd), .dm_rd_o(dm_rd), .dm_wr_o(dm_wr), .ir_wr_o(ir_wr), .pc_wr_o(pc_wr),
        .rf_wr_o(rf_wr), .epc_wr_o(epc_wr), .alu_src_o(alu_src), .ext_op_o(ext_op),
        .rf_waddr_sel_o(waddr_sel), .rf_wdata_sel_o(wdata_sel), .alu_op_o(alu_op),
        .npc_op_o(npc_op), .exc_code_o(exc_code), .exc_flag_o(exc_flag), .state_o(state));

    mc_ctrl #(.ALU_OP_W(3), .TIMEOUT(0), .EXC_EN(1'b1)) dut_nt (
        .clk(clk), .rst(rst), .opcode_i(opcode), .funct_i(funct), .shamt_z_i(shamt_z),
        .alu_zero_i(alu_zero), .alu_ovf_i(alu_ovf), .im_ready_i(im_ready), .dm_ready_i(dm_ready),
        .im_rd_o(n_im_rd), .dm_rd_o(n_dm_rd), .dm_wr_o(n_dm_wr), .ir_wr_o(n_ir_wr), .pc_wr_o(n_pc_wr),
        .rf_wr_o(n_rf_wr), .epc_wr_o(n_epc_wr), .alu_src_o(n_alu_src), .ext_op_o(n_ext_op),
        .rf_waddr_sel_o(n_waddr_sel), .rf_wdata_sel_o(n_wdata_sel), .alu_op_o(n_alu_op),
        .npc_op_o(n_npc_op), .exc_code_o(n_exc_code), .exc_flag_o(n_exc_flag), .state_o(n_state));

    mc_ctrl #(.ALU_OP_W(3), .TIMEOUT(4), .EXC_EN(1'b0)) dut_ne (
        .clk(clk), .rst(rst), .opcode_i(opcode), .funct_i(funct), .shamt_z_i(shamt_z),
        .alu_zero_i(alu_zero), .alu_ovf_i(alu_ovf), .im_ready_i(im_ready), .dm_ready_i(dm_ready),
        .im_rd_o(e_im_rd), .dm_rd_o(e_dm_rd), .dm_wr_o(e_dm_wr), .ir_wr_o(e_ir_wr), .pc_wr_o(e_pc_wr),
        .rf_wr_o(e_rf_wr), .epc_wr_o(e_epc_wr), .alu_src_o(e_alu_src), .ext_op_o(e_ext_op),
        .rf_waddr_sel_o(e_waddr_sel), .rf_wdata_sel_o(e_wdata_sel), .alu_op_o(e_alu_op),
        .npc_op_o(e_npc_op), .exc_code_o(e_exc_code), .exc_flag_o(e_exc_flag), .state_o(e_state));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        opcode = '0; funct = '0; shamt_z = 1'b0; alu_zero = 1'b0;
        alu_ovf = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; im_ready = 1'b1; opcode = OP_LW;
        #1;
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (im_rd !== 1'b1) begin n_err++; $display("FAIL reset_im_rd: got %b want 1", im_rd); end
        n_cmp++; if ({ir_wr, pc_wr, rf_wr, epc_wr, dm_wr, dm_rd} !== 6'b0) begin
            n_err++; $display("FAIL reset_wr_en: got %b want 000000", {ir_wr, pc_wr, rf_wr, epc_wr, dm_wr, dm_rd}); end
        n_cmp++; if ({exc_flag, exc_code} !== 6'b0) begin
            n_err++; $display("FAIL reset_exc: got flag %b code %0d want 0 0", exc_flag, exc_code); end
        @(posedge clk);
        #1;
        rst = 1'b0; im_ready = 1'b0;
    endtask

    task automatic test_addu();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        int rf_cnt = 0;
        logic [1:0] wsel = 2'd3;
        apply_reset();
        opcode = 6'b000000; funct = 6'b100001; shamt_z = 1'b1; im_ready = 1'b1; dm_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (state !== exp_st[c]) begin n_err++; $display("FAIL addu_state[%0d]: got %0d want %0d", c, state, exp_st[c]); end
            if (rf_wr) begin rf_cnt++; wsel = waddr_sel; end
            tick();
        end
        n_cmp++; if (rf_cnt != 1) begin n_err++; $display("FAIL addu_rf_wr_count: got %0d want 1", rf_cnt); end
        n_cmp++; if (wsel !== 2'd0) begin n_err++; $display("FAIL addu_waddr_sel: got %0d want 0", wsel); end
    endtask

    task automatic test_lw();
        int rd_cnt = 0;
        apply_reset();
        opcode = OP_LW;
        // im_ready rises exactly when the timeout count is reached: ready wins
        for (int i = 0; i < 4; i++) begin
            im_ready = (i == 3);
            #1;
            if (i == 3) begin
                n_cmp++; if (ir_wr !== 1'b1) begin n_err++; $display("FAIL lw_fetch_ir_wr: got %b want 1", ir_wr); end
            end
            tick();
        end
        n_cmp++; if (state !== 4'd1) begin n_err++; $display("FAIL lw_ready_wins: got %0d want 1", state); end
        tick();
        n_cmp++; if ({alu_src, ext_op, alu_op} !== 5'b11000 || state !== 4'd4) begin
            n_err++; $display("FAIL lw_mem_adr: got st %0d src %b ext %b op %0d want 4 1 1 0", state, alu_src, ext_op, alu_op); end
        tick();
        for (int i = 0; i < 4; i++) begin
            dm_ready = (i == 3);
            #1;
            if (dm_rd && state == 4'd5) rd_cnt++;
            tick();
        end
        n_cmp++; if (rd_cnt != 4) begin n_err++; $display("FAIL lw_dm_rd_cycles: got %0d want 4", rd_cnt); end
        n_cmp++; if ({state, rf_wr, wdata_sel, waddr_sel} !== {4'd7, 1'b1, 2'd1, 2'd1}) begin
            n_err++; $display("FAIL lw_mem_wb: got st %0d rf_wr %b wd %0d wa %0d want 7 1 1 1", state, rf_wr, wdata_sel, waddr_sel); end
        tick();
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL lw_back_fetch: got %0d want 0", state); end
    endtask

    task automatic test_overflow();
        apply_reset();
        opcode = 6'b000000; funct = 6'b100000; shamt_z = 1'b1; alu_ovf = 1'b1; im_ready = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if (state !== 4'd2 || rf_wr !== 1'b0) begin n_err++; $display("FAIL ovf_alu_exe: got st %0d rf_wr %b want 2 0", state, rf_wr); end
        tick();
        n_cmp++; if ({state, epc_wr, pc_wr, npc_op, rf_wr} !== {4'd10, 1'b1, 1'b1, 2'd3, 1'b0}) begin
            n_err++; $display("FAIL ovf_exc: got st %0d epc %b pc %b npc %0d rf %b want 10 1 1 3 0", state, epc_wr, pc_wr, npc_op, rf_wr); end
        tick();
        n_cmp++; if (state !== 4'd0 || exc_code !== 5'd12 || exc_flag !== 1'b1) begin
            n_err++; $display("FAIL ovf_code: got st %0d code %0d flag %b want 0 12 1", state, exc_code, exc_flag); end
        alu_ovf = 1'b0;
    endtask

    task automatic test_beq();
        apply_reset();
        opcode = OP_BEQ; im_ready = 1'b1; alu_zero = 1'b0;
        tick(); tick();
        #1;
        n_cmp++; if ({state, pc_wr, npc_op, alu_op} !== {4'd8, 1'b0, 2'd0, 3'd1}) begin
            n_err++; $display("FAIL beq_not_taken: got st %0d pc %b npc %0d op %0d want 8 0 0 1", state, pc_wr, npc_op, alu_op); end
        tick(); tick(); tick();
        alu_zero = 1'b1;
        #1;
        n_cmp++; if ({state, pc_wr, npc_op} !== {4'd8, 1'b1, 2'd1}) begin
            n_err++; $display("FAIL beq_taken: got st %0d pc %b npc %0d want 8 1 1", state, pc_wr, npc_op); end
        alu_zero = 1'b0;
    endtask

    task automatic test_jump();
        apply_reset();
        opcode = OP_JAL; im_ready = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if ({state, pc_wr, npc_op, rf_wr, waddr_sel, wdata_sel} !== {4'd9, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2}) begin
            n_err++; $display("FAIL jal: got st %0d pc %b npc %0d rf %b wa %0d wd %0d want 9 1 2 1 2 2",
                              state, pc_wr, npc_op, rf_wr, waddr_sel, wdata_sel); end
        tick();
        opcode = 6'b000000; funct = 6'b001000;
        tick(); tick();
        #1;
        n_cmp++; if ({state, pc_wr, npc_op, rf_wr} !== {4'd9, 1'b1, 2'd2, 1'b0}) begin
            n_err++; $display("FAIL jr: got st %0d pc %b npc %0d rf %b want 9 1 2 0", state, pc_wr, npc_op, rf_wr); end
    endtask

    task automatic test_ori_sw();
        apply_reset();
        opcode = OP_ORI; im_ready = 1'b1; dm_ready = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if ({state, alu_op, alu_src, ext_op} !== {4'd2, 3'd2, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL ori_exe: got st %0d op %0d src %b ext %b want 2 2 1 0", state, alu_op, alu_src, ext_op); end
        tick();
        n_cmp++; if ({state, rf_wr, waddr_sel, wdata_sel} !== {4'd3, 1'b1, 2'd1, 2'd0}) begin
            n_err++; $display("FAIL ori_wb: got st %0d rf %b wa %0d wd %0d want 3 1 1 0", state, rf_wr, waddr_sel, wdata_sel); end
        tick();
        opcode = OP_SW;
        tick(); tick(); tick();
        #1;
        n_cmp++; if ({state, dm_wr, rf_wr} !== {4'd6, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL sw_mem_wr: got st %0d dm_wr %b rf %b want 6 1 0", state, dm_wr, rf_wr); end
        tick();
        n_cmp++; if (state !== 4'd0) begin n_err++; $display("FAIL sw_back_fetch: got %0d want 0", state); end
    endtask

    task automatic test_timeout();
        int fetch_cnt = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            if (state == 4'd0 && im_rd) fetch_cnt++;
            tick();
        end
        n_cmp++; if (fetch_cnt != 4 || state !== 4'd10) begin
            n_err++; $display("FAIL ifetch_timeout: got fetch %0d st %0d want 4 10", fetch_cnt, state); end
        tick();
        n_cmp++; if (exc_code !== 5'd6 || exc_flag !== 1'b1) begin
            n_err++; $display("FAIL ifetch_code: got %0d flag %b want 6 1", exc_code, exc_flag); end
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if ({n_state, n_im_rd, n_exc_flag} !== {4'd0, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL no_timeout_hold: got st %0d im_rd %b flag %b want 0 1 0", n_state, n_im_rd, n_exc_flag); end
        apply_reset();
        opcode = OP_LW; im_ready = 1'b1;
        tick(); tick(); tick();
        fetch_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (state == 4'd5 && dm_rd) fetch_cnt++;
            tick();
        end
        n_cmp++; if (fetch_cnt != 4 || state !== 4'd10) begin
            n_err++; $display("FAIL dbus_timeout: got wait %0d st %0d want 4 10", fetch_cnt, state); end
        tick();
        n_cmp++; if (exc_code !== 5'd7) begin n_err++; $display("FAIL dbus_code: got %0d want 7", exc_code); end
    endtask

    task automatic test_reserved();
        apply_reset();
        opcode = 6'b111111; im_ready = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if (state !== 4'd10 || e_state !== 4'd0) begin
            n_err++; $display("FAIL reserved_route: got st %0d noexc_st %0d want 10 0", state, e_state); end
        tick();
        n_cmp++; if (exc_code !== 5'd10 || e_exc_flag !== 1'b0) begin
            n_err++; $display("FAIL reserved_code: got %0d noexc_flag %b want 10 0", exc_code, e_exc_flag); end
    endtask

    task automatic test_rst_mid_write();
        apply_reset();
        opcode = OP_SW; im_ready = 1'b1; dm_ready = 1'b0;
        tick(); tick(); tick();
        #1;
        n_cmp++; if (state !== 4'd6 || dm_wr !== 1'b1) begin
            n_err++; $display("FAIL pre_rst_mem_wr: got st %0d dm_wr %b want 6 1", state, dm_wr); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({state, dm_wr, im_rd, pc_wr, ir_wr} !== {4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL rst_abort: got st %0d dm_wr %b im_rd %b pc %b ir %b want 0 0 1 0 0",
                              state, dm_wr, im_rd, pc_wr, ir_wr); end
        @(posedge clk);
        #1;
        rst = 1'b0; im_ready = 1'b0; dm_ready = 1'b1;
        #1;
        n_cmp++; if ({state, dm_wr, rf_wr, pc_wr} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL post_rst_quiet: got st %0d dm_wr %b rf %b pc %b want 0 0 0 0", state, dm_wr, rf_wr, pc_wr); end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw();
        test_overflow();
        test_beq();
        test_jump();
        test_ori_sw();
        test_timeout();
        test_reserved();
        test_reset();
        test_rst_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter ALU_OP_W, default 3: width of alu_op; encodings 0 add, 1 sub, 2 or, 3 lui, others reserved.
REQ-002 Parameter TIMEOUT, default 15: maximum wait cycles for im_ready/dm_ready; 0 disables the timeout (wait forever).
REQ-003 Parameter EXC_EN, default 1: 1 enables the overflow, reserved-instruction and bus-error exceptions; 0 means none of them ever raises.
REQ-004 clk  in  1  clock; reset rst, asynchronous, active-high.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 opcode  in  6  ins[31:26] from the external IR.
REQ-007 funct  in  6  ins[5:0]; shamt_z  in  1  ins[10:6]==0.
REQ-008 alu_zero  in  1  ALU operands equal; alu_ovf  in  1  signed overflow of the current ALU result.
REQ-009 im_ready  in  1  instruction memory data valid; dm_ready  in  1  data memory access complete.
REQ-010 im_rd, dm_rd, dm_wr  out  1  memory strobes, held for the whole wait.
REQ-011 ir_wr, pc_wr, rf_wr, epc_wr  out  1  register write enables.
REQ-012 alu_src  out  1  0 = rt data, 1 = extended imm; ext_op  out  1  1 = sign extend, 0 = zero extend.
REQ-013 rf_waddr_sel  out  2  0 rd, 1 rt, 2 r31; rf_wdata_sel  out  2  0 alu_reg, 1 dm_reg, 2 pc.
REQ-014 alu_op  out  ALU_OP_W; npc_op  out  2  0 pc+4, 1 branch, 2 jump (j/jal), 3 exception vector.
REQ-015 exc_code  out  5  last exception cause; exc_flag  out  1  sticky, set on any exception.
REQ-016 state_o  out  4  current state, for debug.

Function
REQ-017 Supported: addu, subu, add, sub (R-type with shamt_z=1), ori, lui, lw, sw, beq, j, jal, jr (funct 001000); anything else is reserved.
REQ-018 States: FETCH, DECODE, ALU_EXE, ALU_WB, MEM_ADR, MEM_RD, MEM_WR, MEM_WB, BR_EXE, JMP_EXE, EXC.
REQ-019 FETCH:
- im_rd=1.
- On im_ready=1: ir_wr=1, pc_wr=1, npc_op=0, go to DECODE.
- Otherwise stay in FETCH.
REQ-020 DECODE routes:
- R-ALU, ori, lui -> ALU_EXE.
- lw, sw -> MEM_ADR.
- beq -> BR_EXE.
- j, jal, jr -> JMP_EXE.
- Reserved -> EXC (code 10) if EXC_EN=1, else FETCH.
REQ-021 ALU_EXE:
- alu_op per instruction; alu_src=1 for ori/lui; ext_op=0 for ori.
- If add/sub, alu_ovf=1 and EXC_EN=1: go to EXC (code 12); no register write occurs.
- Otherwise go to ALU_WB.
REQ-022 ALU_WB: rf_wr=1, rf_wdata_sel=0, rf_waddr_sel = 1 for ori/lui, else 0; then FETCH.
REQ-023 MEM_ADR: alu_op=add, alu_src=1, ext_op=1; lw -> MEM_RD, sw -> MEM_WR.
REQ-024 MEM_RD/MEM_WR:
- Assert dm_rd/dm_wr until dm_ready=1.
- Then MEM_RD -> MEM_WB, MEM_WR -> FETCH.
REQ-025 MEM_WB: rf_wr=1, rf_wdata_sel=1, rf_waddr_sel=1; then FETCH.
REQ-026 BR_EXE:
- alu_op=sub.
- pc_wr = alu_zero (Mealy, same cycle); npc_op=1 when pc_wr=1.
- Then FETCH.
REQ-027 JMP_EXE:
- pc_wr=1, npc_op=2 (jr uses npc_op=2 with the jr flag externally selecting rs).
- jal also rf_wr=1, rf_waddr_sel=2, rf_wdata_sel=2.
- Then FETCH.
REQ-028 Timeout counter:
- Counts consecutive ready-low cycles in FETCH, MEM_RD and MEM_WR; cleared on every state change.
- If TIMEOUT>0, ready is still low and the count reaches TIMEOUT-1, go to EXC with code 6 (FETCH) or 7 (MEM_*).
REQ-029 EXC: one cycle; epc_wr=1, pc_wr=1, npc_op=3, exc_flag<=1, exc_code<=cause; then FETCH.
REQ-030 Write enables, strobes and epc_wr are 0 in every state not listed for them; unused selects are driven 0, never X.
REQ-031 If ready and timeout coincide in the same cycle, ready wins.

Reset
REQ-032 On rst, immediately: state=FETCH, counter=0, exc_code=0, exc_flag=0.
REQ-033 All combinational outputs take their FETCH values during reset (im_rd=1, all write enables 0).
REQ-034 rst asserted mid-access aborts the access; no write enable is asserted after reset releases until the next FETCH/ready.

Verification
REQ-035 addu, im_ready and dm_ready tied 1 -> FETCH, DECODE, ALU_EXE, ALU_WB, FETCH; rf_wr=1 exactly once with rf_waddr_sel=0.
REQ-036 lw with dm_ready low for 3 cycles -> dm_rd high for 4 cycles, then MEM_WB with rf_wdata_sel=1; 6 states total plus waits.
REQ-037 add with alu_ovf=1 in ALU_EXE -> EXC next cycle, exc_code=12, epc_wr=1, npc_op=3, rf_wr never 1.
REQ-038 beq with alu_zero=0, then with alu_zero=1 -> pc_wr 0, then 1 with npc_op=1.
REQ-039 TIMEOUT=4, im_ready held 0 -> EXC entered after 4 FETCH cycles, exc_code=6; with TIMEOUT=0 FETCH holds indefinitely.
REQ-040 opcode 6'b111111 -> EXC with exc_code=10; rst pulsed during MEM_WR -> state FETCH and dm_wr=0 immediately.
